// File: rtl/estado_supervisor.sv
// Initiator-side supervisor for a 4-state cyclic target machine: drives restart/pause
// for a commanded run length, checks every observed step against 0->1->2->3->0 and counts laps.
module estado_supervisor #(
    parameter int CNT_W      = 8,
    parameter int RST_CYCLES = 2
) (
    input  logic             iClk,
    input  logic             iRestart,
    input  logic             iStart,
    input  logic             iPauseReq,
    input  logic [CNT_W-1:0] iRunLen,
    input  logic [1:0]       iValorEstado,
    output logic             oRestart,
    output logic             oPause,
    output logic             oBusy,
    output logic             oDone,
    output logic             oError,
    output logic [CNT_W-1:0] oLaps,
    output logic [CNT_W-1:0] oRemaining
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET_TGT = 3'd1,
        S_RUN       = 3'd2,
        S_PAUSED    = 3'd3,
        S_DONE      = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t          state_r;
    state_t          nxt_state_s;
    logic [RC_W-1:0] rst_cnt_r;
    logic [1:0]      prev_state_r;
    logic            prev_restart_r;
    logic            prev_pause_r;
    logic            chk_pend_r;
    logic            chk_on_r;
    logic [1:0]      expect_s;
    logic            checked_s;
    logic            start_ok_s;
    logic            mismatch_s;
    logic            lap_s;

    // Predict the target state from what it was shown last cycle and flag deviations.
    always_comb begin
        expect_s   = 2'd0;
        checked_s  = 1'b0;
        start_ok_s = 1'b0;
        if (prev_restart_r) begin
            expect_s = 2'd0;
        end else if (prev_pause_r) begin
            expect_s = prev_state_r;
        end else begin
            expect_s = prev_state_r + 2'd1;
        end
        case (state_r)
            S_RESET_TGT, S_RUN, S_PAUSED, S_DONE: checked_s = 1'b1;
            default:                              checked_s = 1'b0;
        endcase
        case (state_r)
            S_IDLE, S_DONE, S_FAULT: start_ok_s = iStart;
            default:                 start_ok_s = 1'b0;
        endcase
        mismatch_s = chk_on_r & checked_s & (iValorEstado != expect_s);
        lap_s      = ~prev_pause_r & ~prev_restart_r & (prev_state_r == 2'd3) &
                     (iValorEstado == 2'd0) & (state_r != S_IDLE) & (state_r != S_FAULT);
    end

    // Next-state selection; a detected mismatch overrides every other transition.
    always_comb begin
        nxt_state_s = state_r;
        if (mismatch_s) begin
            nxt_state_s = S_FAULT;
        end else begin
            case (state_r)
                S_IDLE, S_DONE, S_FAULT: begin
                    if (start_ok_s) nxt_state_s = S_RESET_TGT;
                    else            nxt_state_s = state_r;
                end
                S_RESET_TGT: begin
                    if (rst_cnt_r == RC_W'(1)) begin
                        if (oRemaining == '0) nxt_state_s = S_DONE;
                        else                  nxt_state_s = S_RUN;
                    end else begin
                        nxt_state_s = S_RESET_TGT;
                    end
                end
                S_RUN: begin
                    if (oRemaining == CNT_W'(1)) nxt_state_s = S_DONE;
                    else if (iPauseReq)          nxt_state_s = S_PAUSED;
                    else                         nxt_state_s = S_RUN;
                end
                S_PAUSED: begin
                    if (iPauseReq) nxt_state_s = S_PAUSED;
                    else           nxt_state_s = S_RUN;
                end
                default: nxt_state_s = S_IDLE;
            endcase
        end
    end

    // State, history for the checker, counters and registered outputs.
    always_ff @(posedge iClk) begin
        if (iRestart) begin
            state_r        <= S_IDLE;
            rst_cnt_r      <= '0;
            prev_state_r   <= 2'd0;
            prev_restart_r <= 1'b0;
            prev_pause_r   <= 1'b1;
            chk_pend_r     <= 1'b0;
            chk_on_r       <= 1'b0;
            oRestart       <= 1'b0;
            oPause         <= 1'b1;
            oBusy          <= 1'b0;
            oDone          <= 1'b0;
            oError         <= 1'b0;
            oLaps          <= '0;
            oRemaining     <= '0;
        end else begin
            state_r        <= nxt_state_s;
            prev_state_r   <= iValorEstado;
            prev_restart_r <= oRestart;
            prev_pause_r   <= oPause;
            oRestart       <= (nxt_state_s == S_RESET_TGT);
            oPause         <= (nxt_state_s != S_RUN);
            oBusy          <= (nxt_state_s == S_RESET_TGT) || (nxt_state_s == S_RUN) ||
                              (nxt_state_s == S_PAUSED);
            oDone          <= (nxt_state_s == S_DONE);
            // The first cycle after leaving IDLE still sees pre-run history, so checking waits one more.
            if (state_r == S_IDLE) begin
                chk_pend_r <= start_ok_s;
                chk_on_r   <= 1'b0;
            end else begin
                chk_on_r   <= chk_pend_r;
            end
            if (mismatch_s) begin
                oError <= 1'b1;
            end else if (start_ok_s) begin
                oRemaining <= iRunLen;
                oLaps      <= '0;
                oError     <= 1'b0;
                rst_cnt_r  <= RC_W'(RST_CYCLES);
            end else begin
                if (state_r == S_RESET_TGT) rst_cnt_r  <= rst_cnt_r - RC_W'(1);
                if (state_r == S_RUN)       oRemaining <= oRemaining - CNT_W'(1);
                if (lap_s)                  oLaps      <= oLaps + CNT_W'(1);
            end
        end
    end

endmodule
